// File: rtl/dc_chain.sv
// Delay-commutator cascade: per N-sample block, emits the even/odd split of {x0 block, x1 block} on y0/y1.
// Optional DC_CHAIN_OUT_REG_EN adds one output register (latency N instead of N-1).
module dc_chain #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] x1,
  output logic [DATA_WIDTH-1:0] y0,
  output logic [DATA_WIDTH-1:0] y1,
  output logic                  dc_chain_out_valid
);

  localparam int NUM_STAGES = $clog2(N);

  logic [DATA_WIDTH-1:0] sa [NUM_STAGES+1];
  logic [DATA_WIDTH-1:0] sb [NUM_STAGES+1];
  logic                  sv [NUM_STAGES+1];

  assign sa[0] = x0;
  assign sb[0] = x1;
  assign sv[0] = 1'b1;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int unsigned D  = unsigned'(N) >> (s + 1);
    localparam int unsigned CW = $clog2(2 * D);

    logic [DATA_WIDTH-1:0] dly_b [D];
    logic [DATA_WIDTH-1:0] dly_u [D];
    logic                  vld_d [D];
    logic [CW-1:0]         cnt;
    logic                  swap;
    logic [DATA_WIDTH-1:0] upper;
    logic [DATA_WIDTH-1:0] lower;

    // Upper half of the counter range (cnt >= D) is the crossed switch phase.
    assign swap = cnt[CW-1];

    always_comb begin
      upper = sa[s];
      lower = dly_b[D-1];
      if (swap) begin
        upper = dly_b[D-1];
        lower = sa[s];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        for (int unsigned i = 0; i < D; i++) begin
          dly_b[i] <= '0;
          dly_u[i] <= '0;
          vld_d[i] <= 1'b0;
        end
      end else begin
        dly_b[0] <= sb[s];
        dly_u[0] <= upper;
        vld_d[0] <= sv[s];
        for (int unsigned i = 1; i < D; i++) begin
          dly_b[i] <= dly_b[i-1];
          dly_u[i] <= dly_u[i-1];
          vld_d[i] <= vld_d[i-1];
        end
        if (sv[s]) cnt <= cnt + 1'b1;
      end
    end

    assign sa[s+1] = dly_u[D-1];
    assign sb[s+1] = lower;
    assign sv[s+1] = vld_d[D-1];
  end

  logic [DATA_WIDTH-1:0] y0_q;
  logic [DATA_WIDTH-1:0] y1_q;
  logic                  vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y0_q  <= '0;
      y1_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= sv[NUM_STAGES];
      y0_q  <= sv[NUM_STAGES] ? sa[NUM_STAGES] : '0;
      y1_q  <= sv[NUM_STAGES] ? sb[NUM_STAGES] : '0;
    end
  end

`ifdef DC_CHAIN_OUT_REG_EN
  logic [DATA_WIDTH-1:0] y0_r;
  logic [DATA_WIDTH-1:0] y1_r;
  logic                  vld_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y0_r  <= '0;
      y1_r  <= '0;
      vld_r <= 1'b0;
    end else begin
      y0_r  <= y0_q;
      y1_r  <= y1_q;
      vld_r <= vld_q;
    end
  end

  assign y0                 = y0_r;
  assign y1                 = y1_r;
  assign dc_chain_out_valid = vld_r;
`else
  assign y0                 = y0_q;
  assign y1                 = y1_q;
  assign dc_chain_out_valid = vld_q;
`endif

endmodule

// File: tb/tb_dc_chain.sv
// Scoreboard bench for dc_chain: each driven block pushes its even/odd-split pairs, popped once valid is due.
module tb_dc_chain;

  localparam int DW = 16;
  localparam int N  = 4;
`ifdef DC_CHAIN_OUT_REG_EN
  localparam int L = N;
`else
  localparam int L = N - 1;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] x0    = '0;
  logic [DW-1:0] x1    = '0;
  logic [DW-1:0] y0;
  logic [DW-1:0] y1;
  logic          vld;

  dc_chain #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .x0                (x0),
    .x1                (x1),
    .y0                (y0),
    .y1                (y1),
    .dc_chain_out_valid(vld)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  pair_t         exp_q [$];
  logic [DW-1:0] ba [N];
  logic [DW-1:0] bb [N];
  int            pos      = 0;
  int            edge_cnt = 0;
  int            errors   = 0;
  int            checks   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp_v, edge_cnt);
    end
  endtask

  // One clock: drive a sample pair, then check outputs just after the edge.
  task automatic step(input logic [DW-1:0] a, input logic [DW-1:0] b);
    pair_t p;
    @(negedge clk);
    x0 = a;
    x1 = b;
    ba[pos] = a;
    bb[pos] = b;
    pos++;
    if (pos == N) begin
      for (int m = 0; m < N; m++) begin
        int ia, ib;
        ia = 2 * m;
        ib = 2 * m + 1;
        p.a = (ia < N) ? ba[ia] : bb[ia-N];
        p.b = (ib < N) ? ba[ib] : bb[ib-N];
        exp_q.push_back(p);
      end
      pos = 0;
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    if (edge_cnt >= L + 1) begin
      check("valid_high", 32'(vld), 32'd1);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check("y0", 32'(y0), 32'(p.a));
        check("y1", 32'(y1), 32'(p.b));
      end
    end else begin
      check("valid_low", 32'(vld), 32'd0);
      check("y0_idle", 32'(y0), 32'd0);
      check("y1_idle", 32'(y1), 32'd0);
    end
  endtask

  // Asserts reset mid-cycle, checks the outputs clear at once, releases before the next negedge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    x0    = '0;
    x1    = '0;
    #1;
    check("rst_y0", 32'(y0), 32'd0);
    check("rst_y1", 32'(y1), 32'd0);
    check("rst_valid", 32'(vld), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset    = 1'b1;
    edge_cnt = 0;
    pos      = 0;
    exp_q.delete();
  endtask

  task automatic block_a();
    for (int i = 0; i < N; i++) step(DW'(i), DW'(i + N));
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  logic [DW-1:0] fa [N] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF};
  logic [DW-1:0] fb [N] = '{16'hAAAA, 16'h5555, 16'h1234, 16'hFEDC};

  initial begin
    do_reset();
    block_a();
    zeros(2 * N);

    do_reset();
    block_a();
    for (int i = 0; i < N; i++) step(DW'(i + 2 * N), DW'(i + 3 * N));
    zeros(N + 1);

    do_reset();
    block_a();
    zeros(1);
    do_reset();
    block_a();
    zeros(N);

    do_reset();
    for (int i = 0; i < N; i++) step(fa[i], fb[i]);
    zeros(N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
